// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter: single-port framebuffer SRAM arbiter.
// Display reads get fixed 1-cycle access. A small write FIFO buffers writer
// traffic. A clear engine zero-fills the buffer after draining the FIFO.
// Optional write-stall statistic is compiled in when FB_ARB_STATS_EN is defined.
module fb_sram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int RAM_LENGTH = 1200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_74a,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_data_in,
  input  logic              sram_data_out,
  output logic [15:0]       wr_stall_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_LENGTH - 1);
  localparam logic [ADDR_W:0]   RAM_LEN_X = (ADDR_W + 1)'(RAM_LENGTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] clear_addr;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic              fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              clr_grant;
  logic              head_in_range;
  logic [ADDR_W-1:0] head_addr;
  logic              head_data;

  assign fifo_empty    = (fifo_cnt == '0);
  assign fifo_full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign wr_ready      = !fifo_full && (state != ST_DRAIN);
  assign push          = wr_valid && wr_ready;
  // The FIFO never competes with a read or with the clear engine.
  assign pop           = !fifo_empty && !rd_req && ((state == ST_IDLE) || (state == ST_DRAIN));
  assign clr_grant     = (state == ST_CLEAR) && !rd_req;
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];
  // Out-of-range writer addresses are consumed without touching the SRAM.
  assign head_in_range = ({1'b0, head_addr} < RAM_LEN_X);
  assign clear_busy    = (state != ST_IDLE);
  assign rd_data       = sram_data_out;

  // SRAM port mux: read > clear engine > FIFO head; idle cycles drive zeros.
  always_comb begin
    sram_wr_en   = 1'b0;
    sram_addr    = '0;
    sram_data_in = 1'b0;
    if (rd_req) begin
      sram_addr = rd_addr;
    end else if (clr_grant) begin
      sram_wr_en = 1'b1;
      sram_addr  = clear_addr;
    end else if (pop && head_in_range) begin
      sram_wr_en   = 1'b1;
      sram_addr    = head_addr;
      sram_data_in = head_data;
    end
  end

  // FIFO storage is data only, so it carries no reset.
  always_ff @(posedge clk_74a) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Clear sequencer: drain pending writes, then zero every cell once.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      clear_addr <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_start) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Pushes are blocked here, so a pop of the last entry empties the FIFO.
          if (fifo_empty || ((fifo_cnt == CNT_W'(1)) && pop)) begin
            state      <= ST_CLEAR;
            clear_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_grant) begin
            if (clear_addr == LAST_ADDR) begin
              state      <= ST_IDLE;
              clear_done <= 1'b1;
            end else begin
              clear_addr <= clear_addr + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data valid follows the request by exactly one cycle.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= rd_req;
  end

`ifdef FB_ARB_STATS_EN
  // Count cycles where queued writes are held off by display reads.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      wr_stall_cnt <= '0;
    end else if (!fifo_empty && (state == ST_IDLE) && rd_req && (wr_stall_cnt != 16'hFFFF)) begin
      wr_stall_cnt <= wr_stall_cnt + 1'b1;
    end
  end
`else
  assign wr_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Bench for fb_sram_arbiter: directed table, clear-sequence scenarios,
// and randomized traffic against a queue-based reference model.
module tb_fb_sram_arbiter;

  localparam int ADDR_W     = 11;
  localparam int RAM_LENGTH = 1200;
  localparam int FIFO_DEPTH = 4;
`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk_74a = 1'b0;
  logic              reset_n;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic              sram_wr_en;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_data_in;
  logic              sram_data_out = 1'b0;
  logic [15:0]       wr_stall_cnt;

  fb_sram_arbiter #(.ADDR_W(ADDR_W), .RAM_LENGTH(RAM_LENGTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_74a(clk_74a), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .sram_wr_en(sram_wr_en), .sram_addr(sram_addr), .sram_data_in(sram_data_in),
    .sram_data_out(sram_data_out), .wr_stall_cnt(wr_stall_cnt)
  );

  always #5 clk_74a = ~clk_74a;

  // Behavioural SRAM: registered read, write when enabled.
  bit tb_sram [2048];
  always @(posedge clk_74a) begin
    if (sram_wr_en) tb_sram[sram_addr] <= sram_data_in;
    else            sram_data_out <= tb_sram[sram_addr];
  end

  // Reference model state.
  typedef struct { int addr; bit data; } wr_t;
  wr_t q[$];
  bit  ref_mem [2048];
  int  mode;      // 0 idle, 1 drain, 2 clear
  int  clr_next;
  bit  m_rdv, m_rdd, m_done;
  int  m_stall;

  int n_vec = 0, n_bad = 0;
  int n_done = 0, n_clr = 0, n_wr = 0;

  typedef struct {
    bit rd; int raddr; bit wv; int waddr; bit wd; bit cs;
    bit e_ready; bit e_wr; int e_addr; bit e_din; bit e_rdv; bit e_rdd;
  } vec_t;
  vec_t tab [11];
  bit   tab_on = 1'b0;
  vec_t tab_cur;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode = 0; clr_next = 0; m_rdv = 0; m_rdd = 0; m_done = 0; m_stall = 0;
  endtask

  // One clock: compare at negedge, advance model at posedge, release #1 later.
  task automatic cycle();
    bit e_ready, e_wr, e_din, pop, clrw, nd;
    int e_addr, sz, old_mode;
    @(negedge clk_74a);
    sz      = q.size();
    e_ready = (sz < FIFO_DEPTH) && (mode != 1);
    pop     = (mode != 2) && !rd_req && (sz > 0);
    e_wr = 0; e_addr = 0; e_din = 0; clrw = 0;
    if (rd_req) e_addr = int'(rd_addr);
    else if (mode == 2) begin e_wr = 1; e_addr = clr_next; clrw = 1; end
    else if (pop && (q[0].addr < RAM_LENGTH)) begin
      e_wr = 1; e_addr = q[0].addr; e_din = q[0].data;
    end
    chk("wr_ready", int'(wr_ready), int'(e_ready));
    chk("clear_busy", int'(clear_busy), int'(mode != 0));
    chk("sram_wr_en", int'(sram_wr_en), int'(e_wr));
    chk("sram_addr", int'(sram_addr), e_addr);
    if (!rd_req) chk("sram_data_in", int'(sram_data_in), int'(e_din));
    chk("rd_valid", int'(rd_valid), int'(m_rdv));
    if (m_rdv) chk("rd_data", int'(rd_data), int'(m_rdd));
    chk("clear_done", int'(clear_done), int'(m_done));
    chk("wr_stall_cnt", int'(wr_stall_cnt), m_stall);
    if (tab_on) begin
      chk("tab_wr_ready", int'(wr_ready), int'(tab_cur.e_ready));
      chk("tab_wr_en", int'(sram_wr_en), int'(tab_cur.e_wr));
      chk("tab_addr", int'(sram_addr), tab_cur.e_addr);
      if (!tab_cur.rd) chk("tab_din", int'(sram_data_in), int'(tab_cur.e_din));
      chk("tab_rd_valid", int'(rd_valid), int'(tab_cur.e_rdv));
      if (tab_cur.e_rdv) chk("tab_rd_data", int'(rd_data), int'(tab_cur.e_rdd));
    end
    if (clear_done) n_done++;
    if (sram_wr_en) n_wr++;
    if (sram_wr_en && clrw) n_clr++;
    @(posedge clk_74a);
    if (e_wr) ref_mem[e_addr] = e_din;
    if (rd_req) m_rdd = ref_mem[rd_addr];
    m_rdv = rd_req;
    if (STATS && sz > 0 && mode == 0 && rd_req && m_stall < 65535) m_stall++;
    if (pop) void'(q.pop_front());
    if (wr_valid && e_ready) q.push_back(wr_t'{int'(wr_addr), wr_data});
    nd = 0;
    old_mode = mode;
    case (old_mode)
      0: if (clear_start) mode = 1;
      1: if (q.size() == 0) begin mode = 2; clr_next = 0; end
      2: if (clrw) begin
           if (clr_next == RAM_LENGTH - 1) begin mode = 0; nd = 1; end
           else clr_next++;
         end
      default: mode = 0;
    endcase
    m_done = nd;
    #1;
  endtask

  task automatic drive(bit rd, int ra, bit wv, int wa, bit wd, bit cs);
    rd_req = rd; rd_addr = ADDR_W'(ra);
    wr_valid = wv; wr_addr = ADDR_W'(wa); wr_data = wd;
    clear_start = cs;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    chk("rst_clear_busy", int'(clear_busy), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_sram_wr_en", int'(sram_wr_en), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_stall", int'(wr_stall_cnt), 0);
    model_reset();
    @(negedge clk_74a);
    reset_n = 1'b1;
    @(posedge clk_74a);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2048; i++) begin
      tb_sram[i] = 1'($urandom_range(0, 1));
      ref_mem[i] = tb_sram[i];
    end
    tb_sram[37] = 1'b1; ref_mem[37] = 1'b1;
    tb_sram[5]  = 1'b0; ref_mem[5]  = 1'b0;

    // Directed table: read latency, FIFO fill under reads, in-order drain.
    tab[0]  = '{1, 37, 0,   0, 0, 0,  1, 0,  37, 0,  0, 0};
    tab[1]  = '{1, 37, 1, 100, 1, 0,  1, 0,  37, 0,  1, 1};
    tab[2]  = '{1,  5, 1, 101, 0, 0,  1, 0,   5, 0,  1, 1};
    tab[3]  = '{1, 37, 1, 102, 1, 0,  1, 0,  37, 0,  1, 0};
    tab[4]  = '{1, 37, 1, 103, 1, 0,  1, 0,  37, 0,  1, 1};
    tab[5]  = '{1, 37, 0,   0, 0, 0,  0, 0,  37, 0,  1, 1};
    tab[6]  = '{0,  0, 0,   0, 0, 0,  0, 1, 100, 1,  1, 1};
    tab[7]  = '{0,  0, 0,   0, 0, 0,  1, 1, 101, 0,  0, 0};
    tab[8]  = '{0,  0, 0,   0, 0, 0,  1, 1, 102, 1,  0, 0};
    tab[9]  = '{0,  0, 0,   0, 0, 0,  1, 1, 103, 1,  0, 0};
    tab[10] = '{0,  0, 0,   0, 0, 0,  1, 0,   0, 0,  0, 0};

    do_reset();
    tab_on = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tab_cur = tab[i];
      drive(tab[i].rd, tab[i].raddr, tab[i].wv, tab[i].waddr, tab[i].wd, tab[i].cs);
      cycle();
    end
    tab_on = 1'b0;

    // Drain-then-clear with two queued entries.
    do_reset();
    drive(1, 10, 1, 200, 1, 0); cycle();
    drive(1, 11, 1, 201, 1, 0); cycle();
    drive(1, 12, 0, 0, 0, 1);   cycle();
    chk("drain_wr_ready", int'(wr_ready), 0);
    n_clr = 0; n_done = 0;
    drive(0, 0, 0, 0, 0, 0);
    begin
      int k;
      for (k = 0; k < 3000; k++) begin
        cycle();
        if (!clear_busy) break;
      end
      chk("clear_finished_in_budget", int'(k < 3000), 1);
    end
    cycle(); cycle();
    chk("clear_write_count", n_clr, RAM_LENGTH);
    chk("clear_done_count", n_done, 1);

    // Clear with reads interleaved every other cycle.
    do_reset();
    drive(0, 0, 0, 0, 0, 1); cycle();
    n_clr = 0; n_done = 0;
    begin
      int k;
      for (k = 0; k < 4000; k++) begin
        drive(k[0], int'($urandom_range(0, 2047)), 0, 0, 0, 0);
        cycle();
        if (!clear_busy) break;
      end
      chk("clear_rd_finished_in_budget", int'(k < 4000), 1);
    end
    drive(0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("clear_rd_write_count", n_clr, RAM_LENGTH);
    chk("clear_rd_done_count", n_done, 1);

    // Reset in the middle of a clear, then an out-of-range write.
    do_reset();
    drive(0, 0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0);
    begin
      int k;
      for (k = 0; k < 2000; k++) begin
        if (mode == 2 && clr_next == 600) break;
        cycle();
      end
      chk("reach_addr_600", int'(k < 2000), 1);
    end
    n_done = 0;
    do_reset();
    chk("mid_reset_busy", int'(clear_busy), 0);
    n_wr = 0;
    drive(0, 0, 1, 1250, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("oob_write_dropped", n_wr, 0);
    chk("no_done_after_reset", n_done, 0);

    // Write-stall statistic: one entry held off by 10 read cycles.
    do_reset();
    drive(1, 3, 1, 300, 1, 0); cycle();
    drive(1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
    chk("stall_count_10", int'(wr_stall_cnt), STATS ? 10 : 0);
    drive(0, 0, 0, 0, 0, 0); cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      drive($urandom_range(0, 9) < 4, int'($urandom_range(0, 2047)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 1300)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_sram_arbiter.md
FB_SRAM_ARBITER -- requirements
Module: fb_sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, SRAM address width.
REQ-002 Parameter RAM_LENGTH, default 1200, number of framebuffer cells (40x30).
REQ-003 Parameter FIFO_DEPTH, default 4, write FIFO entries (power of two, >=2).
REQ-004 clk_74a  in  1  sole clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rd_req  in  1  display read request, this cycle.
REQ-007 rd_addr  in  ADDR_W  display read address.
REQ-008 rd_valid  out  1  read data valid (registered).
REQ-009 rd_data  out  1  read data, equals sram_data_out.
REQ-010 wr_valid  in  1  writer request.
REQ-011 wr_ready  out  1  write FIFO accepts.
REQ-012 wr_addr  in  ADDR_W  write address.
REQ-013 wr_data  in  1  write data.
REQ-014 clear_start  in  1  request full-buffer clear.
REQ-015 clear_busy  out  1  clear sequence in progress (DRAIN or CLEAR).
REQ-016 clear_done  out  1  one-cycle pulse at clear completion.
REQ-017 sram_wr_en, sram_addr[ADDR_W], sram_data_in  out  SRAM port controls.
REQ-018 sram_data_out  in  1  SRAM read data, valid one cycle after address with wr_en=0.
REQ-019 wr_stall_cnt  out  16  write-stall statistic (see Configuration).

Function
REQ-020 Arbitration each cycle, fixed priority: rd_req > clear engine (state CLEAR) > FIFO head; at most one SRAM access per cycle.
REQ-021 rd_req: sram_addr=rd_addr, sram_wr_en=0 combinationally same cycle; rd_valid=1 next cycle; latency exactly 1, never stalled.
REQ-022 sram_wr_en=1 only in cycles granted to clear engine or FIFO pop; idle cycles drive wr_en=0, addr=0, data_in=0.
REQ-023 Write FIFO: push on wr_valid&&wr_ready; wr_ready=!full && state!=DRAIN; in-order pop; simultaneous push/pop keeps count.
REQ-024 FIFO pop only in state IDLE or DRAIN and when not rd_req; pop writes head {addr,data} to SRAM that cycle.
REQ-025 FSM states IDLE, DRAIN, CLEAR.
REQ-026 IDLE -> DRAIN on clear_start; clear_start ignored outside IDLE.
REQ-027 DRAIN -> CLEAR when FIFO empty (same-cycle last pop counts); clear_addr loaded 0.
REQ-028 CLEAR: each non-read cycle writes 0 to clear_addr, then clear_addr+1; read cycles hold clear_addr.
REQ-029 CLEAR -> IDLE after writing address RAM_LENGTH-1; clear_done pulses the cycle after that write.
REQ-030 In CLEAR, pushes accepted until full; popped only after returning to IDLE.
REQ-031 Addresses >= RAM_LENGTH from writer are dropped at pop (no SRAM write, entry consumed).
REQ-032 clear_addr never exceeds RAM_LENGTH-1; no wrap.

Reset
REQ-033 reset_n low asynchronously: FSM=IDLE, FIFO empty, clear_addr=0, rd_valid=0, clear_done=0, wr_stall_cnt=0.
REQ-034 During/after reset, clear_busy=0, wr_ready=1, sram_wr_en=0 unless rd_req (then read drive only).
REQ-035 Reset mid-clear or mid-drain discards FIFO contents and abandons sequence; no clear_done.

Configuration
REQ-036 Macro FB_ARB_STATS_EN defined: wr_stall_cnt increments (saturating at 16'hFFFF) each cycle FIFO non-empty, FSM IDLE, and rd_req=1.
REQ-037 Macro FB_ARB_STATS_EN undefined: wr_stall_cnt tied to 0, no counter logic.

Verification
REQ-038 rd_req=1, rd_addr=37 with cell 37=1 -> next cycle rd_valid=1, rd_data=1; no sram_wr_en that cycle.
REQ-039 Push 4 writes with rd_req held 1 -> wr_ready=0 after 4th, no SRAM writes; release rd_req -> 4 writes in order over 4 cycles.
REQ-040 2 entries queued, clear_start -> DRAIN, wr_ready=0, both written, then 1200 zero writes addr 0..1199, clear_done pulse exactly once.
REQ-041 rd_req toggled every other cycle during CLEAR -> 1200 clear writes total, none skipped/duplicated, all reads return 1-cycle data.
REQ-042 reset_n low at clear_addr=600 -> clear_busy=0, FIFO empty, no clear_done; subsequent write to 1250 dropped.
REQ-043 FB_ARB_STATS_EN defined, 1 entry queued, rd_req=1 for 10 cycles -> wr_stall_cnt=10; undefined -> 0.
